// File: rtl/dl_reg_arb.sv
// Shared-register write arbiter: NUM_REQ requesters compete to load one NUM_BITS register drained by a valid/ready consumer.
// Define DL_REG_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module dl_reg_arb #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_BITS-1:0]          q,
  output logic                         q_vld,
  input  logic                         q_rdy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  logic [NUM_BITS-1:0] data_q, data_d;
  logic                vld_q, vld_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic                load;
  logic                found;
  int                  gidx;
  logic [NUM_REQ-1:0]  gnt_onehot;

  // A slot opens when the register is empty or being drained this cycle.
  assign load = (|req) & rst_n & (~vld_q | q_rdy);

`ifdef DL_REG_ARB_RR_EN
  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = 0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    gidx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        gidx  = i;
      end
    end
  end
`endif

  always_comb begin
    gnt_onehot = '0;
    if (load && found) gnt_onehot[gidx] = 1'b1;
  end

  assign gnt = gnt_onehot;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load) begin
      data_d = req_data[gidx*NUM_BITS +: NUM_BITS];
      vld_d  = 1'b1;
      ptr_d  = PTR_W'(gidx);
    end else if (q_rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= PTR_RST;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign q     = data_q;
  assign q_vld = vld_q;

endmodule

// File: tb/tb_dl_reg_arb.sv
// Directed bench for dl_reg_arb (NUM_REQ=4, NUM_BITS=8); expectations follow the DL_REG_ARB_RR_EN setting of the build.
module tb_dl_reg_arb;

  localparam int NR = 4;
  localparam int NB = 8;

`ifdef DL_REG_ARB_RR_EN
  localparam logic [3:0] FAIR_G [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [7:0] FAIR_Q [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
  localparam logic [3:0] ALT_G  [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  localparam logic [7:0] ALT_Q  [4] = '{8'h5A, 8'h6B, 8'h5A, 8'h6B};
`else
  localparam logic [3:0] FAIR_G [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
  localparam logic [7:0] FAIR_Q [5] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
  localparam logic [3:0] ALT_G  [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
  localparam logic [7:0] ALT_Q  [4] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*NB-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [NB-1:0]    q;
  logic             q_vld;
  logic             q_rdy;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  dl_reg_arb #(.NUM_REQ(NR), .NUM_BITS(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .q        (q),
    .q_vld    (q_vld),
    .q_rdy    (q_rdy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    q_rdy = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("rst_q", q, 8'h00);
      check("rst_vld", q_vld, 1'b0);
      check("rst_gnt", gnt, 4'b0000);
    end
    req = 4'b1111;
    #1;
    check("rst_gnt_forced", gnt, 4'b0000);
    tick();

    // Single write from requester 2
    rst_n = 1'b1;
    req   = 4'b0100;
    set_data(8'h11, 8'h00, 8'hA5, 8'h00);
    #1;
    check("single_gnt", gnt, 4'b0100);
    tick();
    req = 4'b0000;
    #1;
    check("single_q", q, 8'hA5);
    check("single_vld", q_vld, 1'b1);

    // Back-pressure holds the register and withholds the grant
    req = 4'b0001;
    #1;
    check("bp_gnt", gnt, 4'b0000);
    tick();
    check("bp_q_hold", q, 8'hA5);
    check("bp_vld", q_vld, 1'b1);
    q_rdy = 1'b1;
    #1;
    check("bp_rel_gnt", gnt, 4'b0001);
    tick();
    check("bp_rel_q", q, 8'h11);
    check("bp_rel_vld", q_vld, 1'b1);

    // Drain, then ready with nothing valid
    req = 4'b0000;
    #1;
    check("drain_gnt", gnt, 4'b0000);
    tick();
    check("drain_vld", q_vld, 1'b0);
    check("drain_q_hold", q, 8'h11);
    tick();
    check("idle_rdy_vld", q_vld, 1'b0);

    // Reset in the middle of a held transfer
    q_rdy = 1'b0;
    req   = 4'b0010;
    set_data(8'h00, 8'h3C, 8'h00, 8'h00);
    #1;
    check("mid_load_gnt", gnt, 4'b0010);
    tick();
    check("mid_q", q, 8'h3C);
    check("mid_vld", q_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 4'b0000);
    tick();
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_vld", q_vld, 1'b0);
    rst_n = 1'b1;

    // All requesters asserted with a consumer that is always ready
    req   = 4'b1111;
    q_rdy = 1'b1;
    set_data(8'h10, 8'h21, 8'h32, 8'h43);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("fair_gnt%0d", i), gnt, FAIR_G[i]);
      tick();
      check($sformatf("fair_q%0d", i), q, FAIR_Q[i]);
      check($sformatf("fair_vld%0d", i), q_vld, 1'b1);
    end

    // Requesters 1 and 3 only
    req = 4'b1010;
    set_data(8'h00, 8'h5A, 8'h00, 8'h6B);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("alt_gnt%0d", i), gnt, ALT_G[i]);
      tick();
      check($sformatf("alt_q%0d", i), q, ALT_Q[i]);
    end

    req = 4'b0000;
    tick();
    check("end_vld", q_vld, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dl_reg_arb.md
DL_REG_ARB -- requirements
Module: dl_reg_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..16).
REQ-002 The block SHALL have parameter NUM_BITS, default 32, meaning the width of the shared register.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port req  input  NUM_REQ  per-requester write request, bit i = requester i.
REQ-007 Port req_data  input  NUM_REQ*NUM_BITS  packed write data, requester i at bits [i*NUM_BITS +: NUM_BITS].
REQ-008 Port gnt  output  NUM_REQ  one-hot grant, combinational, valid in the same cycle as req.
REQ-009 Port q  output  NUM_BITS  shared register contents.
REQ-010 Port q_vld  output  1  q holds unconsumed data.
REQ-011 Port q_rdy  input  1  consumer accepts q this cycle when q_vld=1.

Function
REQ-012 The block SHALL contain one NUM_BITS shared register (q) with a load enable, plus a valid flag (q_vld) and a grant pointer (ptr, clog2(NUM_REQ) bits).
REQ-013 Definition: load = (|req) & rst_n & (!q_vld | q_rdy).
REQ-014 gnt SHALL be all-zero when load=0, and exactly one-hot on a requesting bit when load=1.
REQ-015 A requester is granted only while its req bit is 1; a granted requester's transfer completes in that cycle (req/gnt is a single-cycle handshake; no grant holding).
REQ-016 On load, q SHALL take the granted requester's data at the next rising edge (one-cycle latency from grant to q); otherwise q SHALL hold.
REQ-017 q_vld next-state: 1 if load; else 0 if q_rdy; else hold.
REQ-018 Simultaneous drain and load (q_vld=1, q_rdy=1, |req=1) SHALL replace q with new data and keep q_vld=1 with no bubble cycle.
REQ-019 q_rdy while q_vld=0 SHALL have no effect.
REQ-020 ptr SHALL update to the granted index on load and hold otherwise.
REQ-021 Ungranted requesters SHALL see gnt bit 0 and must hold req and data; the block keeps no per-requester pending state.

Reset
REQ-022 While rst_n=0 at a rising edge: q=0, q_vld=0, ptr=NUM_REQ-1.
REQ-023 gnt SHALL be forced to all-zero during any cycle with rst_n=0.
REQ-024 Reset asserted mid-transfer SHALL discard the held data; no load occurs in that cycle.

Configuration
REQ-025 Macro DL_REG_ARB_RR_EN SHALL select the arbitration policy.
REQ-026 With DL_REG_ARB_RR_EN defined: round-robin; search starts at index ptr+1, wrapping from NUM_REQ-1 to 0; the first requesting index wins.
REQ-027 Without DL_REG_ARB_RR_EN: fixed priority, lowest requesting index wins; ptr is still maintained but does not affect the grant.

Verification (NUM_REQ=4, NUM_BITS=8, RR enabled unless noted)
REQ-028 Reset then idle: rst_n=0 two cycles, req=0 -> q=0x00, q_vld=0, gnt=0000 every cycle.
REQ-029 Single write: req=0100, data2=0xA5, q_vld=0 -> gnt=0100 same cycle; next cycle q=0xA5, q_vld=1.
REQ-030 Back-pressure: q_vld=1, q_rdy=0, req=0001 -> gnt=0000, q unchanged; set q_rdy=1 -> gnt=0001 that cycle, q=data0 next cycle, q_vld stays 1.
REQ-031 Round-robin fairness: req=1111 held, q_rdy=1 constantly -> gnt sequence 0001,0010,0100,1000,0001; q follows data0..data3 one cycle later.
REQ-032 Fixed priority (macro undefined): req=1010 held, q_rdy=1 -> gnt=0010 every cycle; requester 3 never granted.
REQ-033 Reset mid-operation: q_vld=1, q=0x3C, req=0010, rst_n=0 one cycle -> gnt=0000 that cycle, then q=0x00, q_vld=0, next grant goes to requester 0 first if requesting (ptr=3).
